// File: rtl/csr_pkg.sv
// Shared encodings for the CSR access arbiter: op codes, FSM states,
// the latched request record and the read-only address decode.
package csr_pkg;

  localparam logic [1:0] CSR_OP_READ  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] CSR_READONLY_BITS = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [11:0] address;
    logic [31:0] data;
  } csrReq_t;

  function automatic logic is_readonly(input logic [11:0] address);
    return address[11:10] == CSR_READONLY_BITS;
  endfunction

endpackage

// File: rtl/csr_rmw_compute.sv
// Combinational read-modify-write datapath: new CSR value from op/old/data,
// plus whether the op actually needs a write cycle.
module csr_rmw_compute
  import csr_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] oldValue,
  input  logic [31:0] data,
  output logic [31:0] newValue,
  output logic        writeNeeded
);

  always_comb begin
    newValue    = oldValue;
    writeNeeded = 1'b0;
    case (op)
      CSR_OP_WRITE: begin
        newValue    = data;
        writeNeeded = 1'b1;
      end
      // Set/clear with an empty mask cannot change anything, so skip the write.
      CSR_OP_SET: begin
        newValue    = oldValue | data;
        writeNeeded = |data;
      end
      CSR_OP_CLEAR: begin
        newValue    = oldValue & ~data;
        writeNeeded = |data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_access_arbiter.sv
// Shares the CSR file port between core and (with CSR_DEBUG_PORT_EN) a debug
// requester; each op is an atomic READ -> [WRITE] -> DONE sequence.
module csr_access_arbiter
  import csr_pkg::*;
#(
  parameter bit DEBUG_PRIORITY = 1'b1,
  parameter bit READONLY_ERROR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic [1:0]  core_op,
  input  logic [11:0] core_address,
  input  logic [31:0] core_writeData,
  output logic [31:0] core_readData,
  output logic        core_ack,
  output logic        core_error,
`ifdef CSR_DEBUG_PORT_EN
  input  logic        dbg_req,
  input  logic [1:0]  dbg_op,
  input  logic [11:0] dbg_address,
  input  logic [31:0] dbg_writeData,
  output logic [31:0] dbg_readData,
  output logic        dbg_ack,
  output logic        dbg_error,
`endif
  output logic        csrReadEnable,
  output logic [11:0] csrReadAddress,
  input  logic [31:0] csrReadData,
  output logic        csrWriteEnable,
  output logic [11:0] csrWriteAddress,
  output logic [31:0] csrWriteData
);

  logic [1:0]  state;
  csrReq_t     latched;
  csrReq_t     selReq;
  logic        anyReq;
  logic        pickDbg;
  logic        grantDbg;
  logic [31:0] oldValue;
  logic        errFlag;
  logic [31:0] newValue;
  logic        writeNeeded;
  logic        readOnly;
  logic        opDone;

`ifdef CSR_DEBUG_PORT_EN
  assign anyReq  = core_req | dbg_req;
  assign pickDbg = dbg_req & (~core_req | DEBUG_PRIORITY);
  assign selReq  = pickDbg ? '{op: dbg_op, address: dbg_address, data: dbg_writeData}
                           : '{op: core_op, address: core_address, data: core_writeData};
`else
  // Core is the only requester; the priority setting has nothing to decide.
  logic unusedPriority;
  assign unusedPriority = DEBUG_PRIORITY;
  assign anyReq  = core_req;
  assign pickDbg = 1'b0;
  assign selReq  = '{op: core_op, address: core_address, data: core_writeData};
`endif

  assign readOnly = is_readonly(latched.address);

  csr_rmw_compute uRmw (
    .op          (latched.op),
    .oldValue    (oldValue),
    .data        (latched.data),
    .newValue    (newValue),
    .writeNeeded (writeNeeded)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      latched  <= '0;
      grantDbg <= 1'b0;
      oldValue <= '0;
      errFlag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (anyReq) begin
          latched  <= selReq;
          grantDbg <= pickDbg;
          errFlag  <= 1'b0;
          state    <= ST_READ;
        end
        ST_READ: begin
          oldValue <= csrReadData;
          if (!writeNeeded) begin
            state <= ST_DONE;
          end else if (readOnly) begin
            errFlag <= READONLY_ERROR;
            state   <= ST_DONE;
          end else begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Gating with rst keeps an aborted op from committing its write or ack.
  assign csrReadEnable   = (state == ST_READ)  & ~rst;
  assign csrWriteEnable  = (state == ST_WRITE) & ~rst;
  assign csrReadAddress  = latched.address;
  assign csrWriteAddress = latched.address;
  assign csrWriteData    = newValue;
  assign opDone          = (state == ST_DONE) & ~rst;

  assign core_ack      = opDone & ~grantDbg;
  assign core_readData = core_ack ? oldValue : '0;
  assign core_error    = core_ack & errFlag;

`ifdef CSR_DEBUG_PORT_EN
  assign dbg_ack      = opDone & grantDbg;
  assign dbg_readData = dbg_ack ? oldValue : '0;
  assign dbg_error    = dbg_ack & errFlag;
`endif

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Scoreboard bench for csr_access_arbiter: a behavioural CSR file, a reference
// model of expected acks/writes, and negedge monitors that pop and compare.
`timescale 1ns/1ps
module tb_csr_access_arbiter;

  localparam bit DBG_PRIO = 1'b1;
  localparam bit RO_ERR   = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0;
  logic [1:0]  core_op = '0;
  logic [11:0] core_address = '0;
  logic [31:0] core_writeData = '0;
  logic [31:0] core_readData;
  logic        core_ack, core_error;
`ifdef CSR_DEBUG_PORT_EN
  logic        dbg_req = 1'b0;
  logic [1:0]  dbg_op = '0;
  logic [11:0] dbg_address = '0;
  logic [31:0] dbg_writeData = '0;
  logic [31:0] dbg_readData;
  logic        dbg_ack, dbg_error;
`endif
  logic        csrReadEnable, csrWriteEnable;
  logic [11:0] csrReadAddress, csrWriteAddress;
  logic [31:0] csrReadData, csrWriteData;

  always #5 clk = ~clk;

  csr_access_arbiter #(.DEBUG_PRIORITY(DBG_PRIO), .READONLY_ERROR(RO_ERR)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_op(core_op), .core_address(core_address),
    .core_writeData(core_writeData), .core_readData(core_readData),
    .core_ack(core_ack), .core_error(core_error),
`ifdef CSR_DEBUG_PORT_EN
    .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_address(dbg_address),
    .dbg_writeData(dbg_writeData), .dbg_readData(dbg_readData),
    .dbg_ack(dbg_ack), .dbg_error(dbg_error),
`endif
    .csrReadEnable(csrReadEnable), .csrReadAddress(csrReadAddress), .csrReadData(csrReadData),
    .csrWriteEnable(csrWriteEnable), .csrWriteAddress(csrWriteAddress), .csrWriteData(csrWriteData)
  );

  // Power-on CSR contents; a few addresses pinned to the directed-test values.
  function automatic logic [31:0] seedVal(input logic [11:0] a);
    if (a == 12'hF14) return 32'h0000_0003;
    if (a == 12'h300) return 32'h0000_0008;
    return {a, 20'h0} ^ (32'h9E37_79B9 * {20'h0, a});
  endfunction

  // Behavioural CSR file
  bit        written [4096];
  bit [31:0] csrMem  [4096];
  always_comb csrReadData = written[csrReadAddress] ? csrMem[csrReadAddress] : seedVal(csrReadAddress);
  always @(posedge clk) if (csrWriteEnable) begin
    written[csrWriteAddress] <= 1'b1;
    csrMem[csrWriteAddress]  <= csrWriteData;
  end

  typedef struct { logic [31:0] rd; logic err; int cyc; } expAck_t;
  typedef struct { logic [11:0] a; logic [31:0] d; } expWr_t;
  expAck_t coreQ[$];
  expAck_t dbgQ[$];
  expWr_t  wrQ[$];
  logic [31:0] refMem [4096];
  int total = 0, bad = 0, cyc = 0;
  logic [11:0] pool [8] = '{12'h300, 12'h305, 12'h341, 12'hF14, 12'hC00, 12'hC01, 12'h7C0, 12'hB00};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: ops complete one at a time in service order; the top quarter
  // of the CSR space is read-only; empty set/clear masks touch nothing.
  task automatic model(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                       input int seen, output expAck_t e);
    logic [31:0] old, nv;
    bit wr, ro;
    ro = (a >= 12'hC00);
    old = refMem[a];
    e.rd = old; e.err = 1'b0; wr = 0; nv = old;
    case (op)
      2'd1: begin wr = 1; nv = d; end
      2'd2: begin wr = (d != 0); nv = old | d; end
      2'd3: begin wr = (d != 0); nv = old & ~d; end
      default: ;
    endcase
    if (wr && ro) begin wr = 0; e.err = RO_ERR; end
    e.cyc = seen + (wr ? 3 : 2);
    if (wr) begin
      refMem[a] = nv;
      wrQ.push_back('{a: a, d: nv});
    end
  endtask

  always @(negedge clk) begin : mon
    expAck_t e;
    expWr_t  w;
    if (core_ack) begin
      if (coreQ.size() == 0) check("core_ack_unexpected", 1, 0);
      else begin
        e = coreQ.pop_front();
        check("core_readData", core_readData, e.rd);
        check("core_error", {31'b0, core_error}, {31'b0, e.err});
        check("core_ack_cycle", cyc, e.cyc);
      end
    end
`ifdef CSR_DEBUG_PORT_EN
    if (dbg_ack) begin
      if (dbgQ.size() == 0) check("dbg_ack_unexpected", 1, 0);
      else begin
        e = dbgQ.pop_front();
        check("dbg_readData", dbg_readData, e.rd);
        check("dbg_error", {31'b0, dbg_error}, {31'b0, e.err});
        check("dbg_ack_cycle", cyc, e.cyc);
      end
    end
`endif
    if (csrWriteEnable) begin
      check("rw_enable_overlap", {31'b0, csrReadEnable}, 0);
      if (wrQ.size() == 0) check("csr_write_unexpected", {20'b0, csrWriteAddress}, 0);
      else begin
        w = wrQ.pop_front();
        check("csrWriteAddress", {20'b0, csrWriteAddress}, {20'b0, w.a});
        check("csrWriteData", csrWriteData, w.d);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the ack.
  task automatic issueCore(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                           input bit perturb, input bit dropEarly);
    expAck_t e;
    bit got = 0;
    model(op, a, d, cyc, e);
    coreQ.push_back(e);
    core_req = 1; core_op = op; core_address = a; core_writeData = d;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (k == 0 && perturb) begin
        core_op = 2'($urandom); core_address = 12'($urandom); core_writeData = $urandom;
      end
      if (k == 0 && dropEarly) core_req = 0;
      if (core_ack) got = 1;
    end
    core_req = 0;
    if (!got) check("core_ack_timeout", 0, 1);
    @(negedge clk);
  endtask

`ifdef CSR_DEBUG_PORT_EN
  task automatic issueDual(input logic [1:0] opC, input logic [11:0] aC, input logic [31:0] dC,
                           input logic [1:0] opD, input logic [11:0] aD, input logic [31:0] dD);
    expAck_t eC, eD;
    bit gotC = 0, gotD = 0;
    if (DBG_PRIO) begin
      model(opD, aD, dD, cyc, eD);
      model(opC, aC, dC, eD.cyc + 1, eC);
    end else begin
      model(opC, aC, dC, cyc, eC);
      model(opD, aD, dD, eC.cyc + 1, eD);
    end
    coreQ.push_back(eC);
    dbgQ.push_back(eD);
    core_req = 1; core_op = opC; core_address = aC; core_writeData = dC;
    dbg_req  = 1; dbg_op  = opD; dbg_address  = aD; dbg_writeData  = dD;
    for (int k = 0; k < 20 && !(gotC && gotD); k++) begin
      @(negedge clk);
      if (core_ack) begin gotC = 1; core_req = 0; end
      if (dbg_ack)  begin gotD = 1; dbg_req = 0; end
    end
    core_req = 0; dbg_req = 0;
    if (!(gotC && gotD)) check("dual_ack_timeout", {30'b0, gotC, gotD}, 3);
    @(negedge clk);
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [11:0] a;
    logic [31:0] d;
    for (int i = 0; i < 4096; i++) refMem[i] = seedVal(12'(i));

    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_core_ack", {31'b0, core_ack}, 0);
    check("rst_core_error", {31'b0, core_error}, 0);
    check("rst_core_readData", core_readData, 0);
    check("rst_csrReadEnable", {31'b0, csrReadEnable}, 0);
    check("rst_csrWriteEnable", {31'b0, csrWriteEnable}, 0);
    check("rst_csrReadAddress", {20'b0, csrReadAddress}, 0);
    check("rst_csrWriteAddress", {20'b0, csrWriteAddress}, 0);
    check("rst_csrWriteData", csrWriteData, 0);

    issueCore(2'd0, 12'hF14, 32'h0, 0, 0);          // read-only read: legal
    issueCore(2'd2, 12'h300, 32'h0000_0080, 0, 0);  // set -> 0x88
    issueCore(2'd3, 12'h300, 32'h0, 0, 0);          // empty clear mask
    issueCore(2'd3, 12'hC00, 32'h0000_000F, 0, 0);  // read-only clear -> error
    issueCore(2'd0, 12'h300, 32'h0, 1, 0);          // readback, fields disturbed
    issueCore(2'd1, 12'h341, 32'hDEAD_BEEF, 0, 1);  // req dropped mid-op

    // Reset during the WRITE cycle of a core write: no write, no ack.
    core_req = 1; core_op = 2'd1; core_address = 12'h305; core_writeData = 32'h1234_5678;
    @(negedge clk);               // READ
    @(posedge clk); #1 rst = 1;   // now in WRITE
    @(negedge clk);
    check("rstmid_writeEnable", {31'b0, csrWriteEnable}, 0);
    check("rstmid_core_ack", {31'b0, core_ack}, 0);
    @(posedge clk); #1 rst = 0; core_req = 0;
    @(negedge clk);
    check("rstmid_idle_readEnable", {31'b0, csrReadEnable}, 0);
    check("rstmid_idle_writeEnable", {31'b0, csrWriteEnable}, 0);
    check("rstmid_idle_core_ack", {31'b0, core_ack}, 0);
    repeat (3) @(negedge clk);
    check("rstmid_no_write", written[12'h305] ? csrMem[12'h305] : seedVal(12'h305), refMem[12'h305]);
    issueCore(2'd1, 12'h305, 32'h1234_5678, 0, 0);

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : pool[$urandom_range(0, 7)];
      d  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      issueCore(op, a, d, 1'($urandom), ($urandom_range(0, 4) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef CSR_DEBUG_PORT_EN
    issueDual(2'd0, 12'h341, 32'h0, 2'd1, 12'h305, 32'h0000_1000);
    for (int n = 0; n < 20; n++) begin
      issueDual(2'($urandom), pool[$urandom_range(0, 7)], $urandom,
                2'($urandom), pool[$urandom_range(0, 7)], ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
    end
`endif

    repeat (5) @(negedge clk);
    check("leftover_expectations", coreQ.size() + dbgQ.size() + wrQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
